scic_io_port: RTL and testbench



---
 rtl/scic_io_port.sv | 122 ++++++++++++
 tb/tb_scic_io_port.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/scic_io_port.sv
// scic_io_port: memory-mapped I/O port for the SCIC CPU.
// Drives an LED register, debounces the switch inputs and reports switch
// changes through a sticky flag. CPU accesses complete one cycle after the
// strobe with a registered response.
module scic_io_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SW_WIDTH        = 4,
  parameter int unsigned LED_WIDTH       = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  switches,
  input  logic [1:0]           io_addr,
  input  logic                 io_rd,
  input  logic                 io_wr,
  input  logic [31:0]          io_wdata,
  output logic [31:0]          io_rdata,
  output logic                 io_ready,
  output logic [LED_WIDTH-1:0] LEDs
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_SWITCH = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_LED    = 2'd2;

  logic [SW_WIDTH-1:0] sync1;
  logic [SW_WIDTH-1:0] sync2;
  logic [SW_WIDTH-1:0] candidate;
  logic [SW_WIDTH-1:0] debounced;
  logic [CNT_W-1:0]    counter;
  logic                changed;

  logic                stable_c;
  logic                deb_update_c;
  logic                access_c;
  logic                switch_rd_c;
  logic [31:0]         rd_val_c;

  // Decode of the debounce state and of the current CPU access.
  always_comb begin
    stable_c     = (candidate == debounced) && (counter == CNT_MAX);
    deb_update_c = (counter == CNT_MAX) && (candidate == sync2) &&
                   (candidate != debounced);
    access_c     = io_rd | io_wr;
    switch_rd_c  = io_rd && (io_addr == ADDR_SWITCH);
  end

  // Register read mux, evaluated on the pre-edge state.
  always_comb begin
    rd_val_c = 32'd0;
    case (io_addr)
      ADDR_SWITCH: rd_val_c = 32'(debounced);
      ADDR_STATUS: rd_val_c = {30'd0, stable_c, changed};
      ADDR_LED:    rd_val_c = 32'(LEDs);
      default:     rd_val_c = 32'd0;
    endcase
  end

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
    end
  end

  // Candidate tracking with a saturating stability counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      candidate <= '0;
      counter   <= '0;
    end else if (sync2 != candidate) begin
      candidate <= sync2;
      counter   <= '0;
    end else if (counter < CNT_MAX) begin
      counter <= counter + CNT_W'(1);
    end
  end

  // Debounced value and sticky change flag; a set beats a clearing read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      debounced <= '0;
      changed   <= 1'b0;
    end else if (deb_update_c) begin
      debounced <= candidate;
      changed   <= 1'b1;
    end else if (switch_rd_c) begin
      changed <= 1'b0;
    end
  end

  // LED register, written through address 2.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      LEDs <= '0;
    end else if (io_wr && (io_addr == ADDR_LED)) begin
      LEDs <= io_wdata[LED_WIDTH-1:0];
    end
  end

  // One-cycle response: ready pulse plus pre-edge register value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_ready <= 1'b0;
      io_rdata <= 32'd0;
    end else if (access_c) begin
      io_ready <= 1'b1;
      io_rdata <= rd_val_c;
    end else begin
      io_ready <= 1'b0;
      io_rdata <= 32'd0;
    end
  end

endmodule

// File: tb/tb_scic_io_port.sv
// Directed bench for scic_io_port with a table of register accesses and
// hand-written sequences for debounce, coincident read/update and reset.
module tb_scic_io_port;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  switches;
  logic [1:0]  io_addr;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ready;
  logic [3:0]  LEDs;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        exp_ready;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_leds;
  } vec_t;

  vec_t vecs[16];

  scic_io_port #(
    .DEBOUNCE_CYCLES(4),
    .SW_WIDTH(4),
    .LED_WIDTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .switches(switches),
    .io_addr(io_addr),
    .io_rd(io_rd),
    .io_wr(io_wr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .io_ready(io_ready),
    .LEDs(LEDs)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] addr,
                       input logic [31:0] wdata);
    io_rd    = rd;
    io_wr    = wr;
    io_addr  = addr;
    io_wdata = wdata;
  endtask

  task automatic do_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
    drive(1'b1, 1'b0, addr, 32'd0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    check({name, "_ready"}, 32'(io_ready), 32'd1);
    check({name, "_rdata"}, io_rdata, exp);
  endtask

  initial begin
    // Register access table; switches hold 4'hA and changed is clear.
    vecs[0]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0005, 1'b1, 1'b0, 32'h0, 4'h5};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 32'h0,         1'b1, 1'b1, 32'h5, 4'h5};
    vecs[2]  = '{1'b1, 1'b0, 2'd3, 32'h0,         1'b1, 1'b1, 32'h0, 4'h5};
    vecs[3]  = '{1'b0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b1, 32'h0, 4'h5};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 32'hA, 4'h5};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 32'h0,         1'b1, 1'b1, 32'h2, 4'h5};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 32'h0,         1'b1, 1'b1, 32'h5, 4'h5};
    vecs[7]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0009, 1'b1, 1'b1, 32'h5, 4'h9};
    vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'h0,         1'b1, 1'b1, 32'h9, 4'h9};
    vecs[9]  = '{1'b0, 1'b1, 2'd3, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0, 4'h9};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 1'b1, 1'b0, 32'h0, 4'h9};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 32'hA, 4'h9};
    vecs[12] = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FFF3, 1'b1, 1'b0, 32'h0, 4'h3};
    vecs[13] = '{1'b1, 1'b0, 2'd2, 32'h0,         1'b1, 1'b1, 32'h3, 4'h3};
    vecs[14] = '{1'b1, 1'b0, 2'd1, 32'h0,         1'b1, 1'b1, 32'h2, 4'h3};
    vecs[15] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 32'h0, 4'h3};

    // Reset held with switches high and an LED write attempted.
    reset    = 1'b1;
    switches = 4'hA;
    drive(1'b0, 1'b1, 2'd2, 32'h0000_0005);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_leds", 32'(LEDs), 32'd0);
      check("rst_ready", 32'(io_ready), 32'd0);
      check("rst_rdata", io_rdata, 32'd0);
    end
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("post_rst_leds", 32'(LEDs), 32'd0);
    do_read(2'd1, 32'h3, "post_rst_status");
    do_read(2'd0, 32'hA, "post_rst_switch");

    // Table-driven register accesses.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      tick();
      check($sformatf("vec%0d_ready", i), 32'(io_ready), 32'(vecs[i].exp_ready));
      if (vecs[i].chk_rdata)
        check($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_leds", i), 32'(LEDs), 32'(vecs[i].exp_leds));
    end
    drive(1'b0, 1'b0, 2'd0, 32'd0);

    // Bring switches back to zero and clear the flag.
    switches = 4'h0;
    for (int i = 0; i < 10; i++) tick();
    do_read(2'd0, 32'h0, "settle0_switch");
    do_read(2'd1, 32'h2, "settle0_status");

    // 0 -> 3: continuous SWITCH reads; the read at k+6 coincides with the update.
    switches = 4'h3;
    for (int j = 0; j <= 6; j++) begin
      drive(1'b1, 1'b0, 2'd0, 32'd0);
      tick();
      check($sformatf("lat_edge%0d_ready", j), 32'(io_ready), 32'd1);
      check($sformatf("lat_edge%0d_rdata", j), io_rdata, 32'h0);
    end
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    do_read(2'd1, 32'h3, "coincident_status");
    do_read(2'd0, 32'h3, "sw3_switch");
    do_read(2'd1, 32'h2, "sw3_status_cleared");

    // Settle to zero, then bounce shorter than the debounce window.
    switches = 4'h0;
    for (int i = 0; i < 10; i++) tick();
    do_read(2'd0, 32'h0, "pre_bounce_switch");
    do_read(2'd1, 32'h2, "pre_bounce_status");
    for (int i = 0; i < 10; i++) begin
      switches = (i % 2 == 0) ? 4'h1 : 4'h0;
      tick();
      tick();
    end
    switches = 4'h0;
    for (int i = 0; i < 10; i++) tick();
    do_read(2'd1, 32'h2, "bounce_status");
    do_read(2'd0, 32'h0, "bounce_switch");

    // Reset asserted mid-access: response dropped, outputs cleared at once.
    drive(1'b1, 1'b0, 2'd2, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_async_ready", 32'(io_ready), 32'd0);
    check("midrst_async_leds", 32'(LEDs), 32'd0);
    tick();
    check("midrst_ready", 32'(io_ready), 32'd0);
    check("midrst_rdata", io_rdata, 32'd0);
    check("midrst_leds", 32'(LEDs), 32'd0);
    switches = 4'h5;
    tick();
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    reset = 1'b0;
    tick();
    check("after_rst_ready", 32'(io_ready), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    do_read(2'd1, 32'h3, "redeb_status");
    do_read(2'd0, 32'h5, "redeb_switch");
    check("redeb_leds", 32'(LEDs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
